// File: rtl/rs_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : rs_arith_pkg
//  Brief   : Shared types and helpers for the segmented pipelined adder:
//            segment count function, per-stage control struct, carry-in
//            encodings for add and subtract.
//  Revision: 1.0 - initial release
// ============================================================================
package rs_arith_pkg;

    // Carry-in for the least significant segment
    localparam logic CI_ADD = 1'b0;
    localparam logic CI_SUB = 1'b1;

    // Control bits that travel with a beat through the pipeline
    typedef struct packed {
        logic valid;
        logic sub;
        logic carry;
    } stage_ctl_t;

    // Number of carry-chain segments (one pipeline stage each)
    function automatic int seg_count(input int width, input int seg);
        return width / seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rs_seg_add_stage.sv
`default_nettype none
// ============================================================================
//  Module  : rs_seg_add_stage
//  Brief   : One SEG_WIDTH-bit carry-chain segment. Inverts B when
//            subtracting; the caller supplies the carry-in. Purely
//            combinational.
//  Revision: 1.0 - initial release
// ============================================================================
module rs_seg_add_stage #(
    parameter int SEG_WIDTH = 16
) (
    input  logic [SEG_WIDTH-1:0] i_a,
    input  logic [SEG_WIDTH-1:0] i_b,
    input  logic                 i_sub,
    input  logic                 i_cin,
    output logic [SEG_WIDTH-1:0] o_sum,
    output logic                 o_cout
);

    logic [SEG_WIDTH-1:0] w_b_eff;
    logic [SEG_WIDTH:0]   w_total;

    // Subtraction is A + ~B + 1; the +1 arrives through the carry-in
    assign w_b_eff = i_b ^ {SEG_WIDTH{i_sub}};
    assign w_total = {1'b0, i_a} + {1'b0, w_b_eff} + {{SEG_WIDTH{1'b0}}, i_cin};
    assign o_sum   = w_total[SEG_WIDTH-1:0];
    assign o_cout  = w_total[SEG_WIDTH];

endmodule
`default_nettype wire

// File: rtl/rs_seg_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module  : rs_seg_pipe_adder
//  Brief   : Pipelined WIDTH-bit add/subtract, one SEG_WIDTH carry-chain
//            segment per stage with the carry registered between stages.
//            Valid/ready in and out, global stall (bubbles are kept).
//            Optional macro RS_SEG_ADDER_OVF_EN adds a registered signed
//            overflow output (out_ovf).
//  Revision: 1.0 - initial release
// ============================================================================
module rs_seg_pipe_adder #(
    parameter int WIDTH     = 64,
    parameter int SEG_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_co
`ifdef RS_SEG_ADDER_OVF_EN
    ,
    output logic             out_ovf
`endif
);
    import rs_arith_pkg::*;

    localparam int NSEG = seg_count(WIDTH, SEG_WIDTH);
    localparam int MSB  = WIDTH - 1;
    localparam int LAST = NSEG - 1;

    generate
        if ((SEG_WIDTH > WIDTH) || ((WIDTH % SEG_WIDTH) != 0)) begin : g_bad_width
            $error("rs_seg_pipe_adder: WIDTH must be a multiple of SEG_WIDTH");
        end
    endgenerate

    // Stage registers: index k holds the state after stage k has added its segment
    stage_ctl_t       r_ctl_q [NSEG];
    logic [WIDTH-1:0] r_a_q   [NSEG];
    logic [WIDTH-1:0] r_b_q   [NSEG];
    logic [WIDTH-1:0] r_y_q   [NSEG];

    // Stage inputs (previous stage registers, or the input port for stage 0)
    stage_ctl_t       w_ctl_src [NSEG];
    logic [WIDTH-1:0] w_a_src   [NSEG];
    logic [WIDTH-1:0] w_b_src   [NSEG];
    logic [WIDTH-1:0] w_y_src   [NSEG];

    // Next-state values
    stage_ctl_t       w_ctl_d [NSEG];
    logic [WIDTH-1:0] w_y_d   [NSEG];

    logic [SEG_WIDTH-1:0] w_sum  [NSEG];
    logic                 w_cout [NSEG];
    logic                 w_adv;

    // Whole pipe moves together whenever the output slot is free or drained
    assign w_adv    = !r_ctl_q[LAST].valid || out_ready;
    assign in_ready = w_adv;

    // Route each stage's operands: stage 0 from the ports, others from the previous register
    always_comb begin
        for (int k = 1; k < NSEG; k++) begin
            w_ctl_src[k] = r_ctl_q[k-1];
            w_a_src[k]   = r_a_q[k-1];
            w_b_src[k]   = r_b_q[k-1];
            w_y_src[k]   = r_y_q[k-1];
        end
        w_ctl_src[0].valid = in_valid;
        w_ctl_src[0].sub   = in_sub;
        w_ctl_src[0].carry = in_sub ? CI_SUB : CI_ADD;
        w_a_src[0]         = in_a;
        w_b_src[0]         = in_b;
        w_y_src[0]         = '0;
    end

    generate
        for (genvar k = 0; k < NSEG; k++) begin : g_stage
            rs_seg_add_stage #(
                .SEG_WIDTH(SEG_WIDTH)
            ) u_add (
                .i_a   (w_a_src[k][k*SEG_WIDTH +: SEG_WIDTH]),
                .i_b   (w_b_src[k][k*SEG_WIDTH +: SEG_WIDTH]),
                .i_sub (w_ctl_src[k].sub),
                .i_cin (w_ctl_src[k].carry),
                .o_sum (w_sum[k]),
                .o_cout(w_cout[k])
            );
        end
    endgenerate

    // Merge each stage's segment into the partial result and forward its carry
    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            w_y_d[k]                              = w_y_src[k];
            w_y_d[k][k*SEG_WIDTH +: SEG_WIDTH]    = w_sum[k];
            w_ctl_d[k]                            = w_ctl_src[k];
            w_ctl_d[k].carry                      = w_cout[k];
        end
    end

`ifdef RS_SEG_ADDER_OVF_EN
    logic w_ovf_d;
    logic r_ovf_q;

    // Signed overflow: operands (after B inversion) agree in sign, result differs
    always_comb begin
        w_ovf_d = (w_a_src[LAST][MSB] == (w_b_src[LAST][MSB] ^ w_ctl_src[LAST].sub)) &&
                  (w_y_d[LAST][MSB] != w_a_src[LAST][MSB]);
    end

    // Overflow flag travels alongside the final result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_q <= 1'b0;
        end else if (w_adv) begin
            r_ovf_q <= w_ovf_d;
        end
    end

    assign out_ovf = r_ovf_q;
`endif

    // Pipeline registers: reset discards everything in flight, otherwise load on advance
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSEG; k++) begin
                r_ctl_q[k] <= '0;
                r_a_q[k]   <= '0;
                r_b_q[k]   <= '0;
                r_y_q[k]   <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < NSEG; k++) begin
                r_ctl_q[k] <= w_ctl_d[k];
                r_a_q[k]   <= w_a_src[k];
                r_b_q[k]   <= w_b_src[k];
                r_y_q[k]   <= w_y_d[k];
            end
        end
    end

    assign out_valid = r_ctl_q[LAST].valid;
    assign out_y     = r_y_q[LAST];
    assign out_co    = r_ctl_q[LAST].carry;

endmodule
`default_nettype wire
